// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: time-shares one external BCD_adder
// slice, feeding one digit pair per cycle LSD first and assembling the sum.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_s0,
  input  logic                  add_cout,
  input  logic                  add_error,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  cout,
  output logic                  error
);

  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [4*DIGITS-1:0]   r_a_sh;
  logic [4*DIGITS-1:0]   r_b_sh;
  logic [3:0]            r_add_a;
  logic [3:0]            r_add_b;
  logic                  r_add_cin;
  logic [4*DIGITS-1:0]   r_sum;
  logic                  r_cout;
  logic                  r_err;
  logic [CW-1:0]         r_cnt;
  logic                  w_last;
  logic [4*DIGITS+3:0]   w_sum_cat;

  assign w_last    = (r_cnt == CW'(DIGITS - 1));
  // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
  assign w_sum_cat = {add_s0, r_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The shift registers hold the digits still to be issued; the add_* registers
  // carry the digit in flight and keep their last values once ADD finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh    <= a_bcd >> 4;
            r_b_sh    <= b_bcd >> 4;
            r_add_a   <= a_bcd[3:0];
            r_add_b   <= b_bcd[3:0];
            r_add_cin <= cin;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_ADD: begin
          r_sum  <= w_sum_cat[4*DIGITS+3:4];
          r_err  <= r_err | add_error;
          r_a_sh <= r_a_sh >> 4;
          r_b_sh <= r_b_sh >> 4;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= add_cout;
          end else begin
            r_add_a   <= r_a_sh[3:0];
            r_add_b   <= r_b_sh[3:0];
            r_add_cin <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign add_cin = r_add_cin;
  assign busy    = (r_state == S_ADD);
  assign done    = (r_state == S_DONE);
  assign sum_bcd = r_sum;
  assign cout    = r_cout;
  assign error   = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: behavioural BCD slice plus a digit-level reference model
// of the whole serial addition, checked every cycle of each operation.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_bcd, b_bcd;
  logic         cin;
  logic [3:0]   add_a, add_b, add_s0;
  logic         add_cin, add_cout, add_error;
  logic         busy, done, cout, error;
  logic [W-1:0] sum_bcd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s0(add_s0), .add_cout(add_cout), .add_error(add_error),
    .busy(busy), .done(done), .sum_bcd(sum_bcd), .cout(cout), .error(error)
  );

  // One-digit BCD adder slice: {error, cout, s}
  function automatic logic [5:0] slice(input logic [3:0] a, input logic [3:0] b, input logic c);
    int t;
    logic [3:0] s;
    t = int'(a) + int'(b) + int'(c);
    s = (t > 9) ? 4'(t - 10) : 4'(t);
    return {(a > 9) || (b > 9), t > 9, s};
  endfunction

  assign {add_error, add_cout, add_s0} = slice(add_a, add_b, add_cin);

  // Reference: ripple the slice over digits; cins[k] is the carry into digit k.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] s, output logic co, output logic er,
                       output logic [DIGITS-1:0] cins);
    logic [5:0] r;
    s = '0; er = 1'b0; co = c;
    for (int k = 0; k < DIGITS; k++) begin
      cins[k] = co;
      r = slice(4'((a >> (4*k)) & 'hF), 4'((b >> (4*k)) & 'hF), co);
      s = s | (W'(r[3:0]) << (4*k));
      co = r[4];
      er = er | r[5];
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int x = 0;
    for (int k = DIGITS - 1; k >= 0; k--) x = x * 10 + int'((v >> (4*k)) & 'hF);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one operation; spam keeps start high with junk operands through ADD and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit spam);
    logic [W-1:0] es;
    logic eco, eer;
    logic [DIGITS-1:0] ecin;
    model(a, b, c, es, eco, eer, ecin);
    @(negedge clk);
    a_bcd = a; b_bcd = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    if (!spam) start = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      @(negedge clk);
      chk("busy_add", busy, 1);
      chk("done_add", done, 0);
      chk("add_a", add_a, 4'((a >> (4*k)) & 'hF));
      chk("add_b", add_b, 4'((b >> (4*k)) & 'hF));
      chk("add_cin", add_cin, ecin[k]);
      if (spam) begin
        a_bcd = W'($urandom); b_bcd = W'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("sum", sum_bcd, es);
    chk("cout", cout, eco);
    chk("error", error, eer);
    @(negedge clk);
    start = 1'b0;
    chk("done_once", done, 0);
    chk("busy_after", busy, 0);
    chk("sum_hold", sum_bcd, es);
    if (!eer)
      chk("decimal", bcd2int(sum_bcd) + 10000 * int'(cout), bcd2int(a) + bcd2int(b) + int'(c));
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v = '0;
    for (int k = 0; k < DIGITS; k++)
      v = v | (W'((allow_bad && $urandom_range(0, 9) == 0) ? $urandom_range(10, 15)
                                                             : $urandom_range(0, 9)) << (4*k));
    return v;
  endfunction

  initial begin
    logic [W-1:0] ps;
    logic pco, per;
    logic [DIGITS-1:0] pcin;

    // Hand-computed pins on the model itself
    model(16'h1234, 16'h5678, 1'b0, ps, pco, per, pcin);
    chk("pin_6912", {per, pco, ps}, {2'b00, 16'h6912});
    model(16'h9999, 16'h0001, 1'b0, ps, pco, per, pcin);
    chk("pin_9999", {pcin, pco, ps}, {4'b1110, 1'b1, 16'h0000});
    model(16'h0000, 16'h0000, 1'b1, ps, pco, per, pcin);
    chk("pin_cin", {pco, ps}, {1'b0, 16'h0001});

    rst_n = 1'b0; start = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0;
    #1;
    chk("rst_state", {busy, done, cout, error, sum_bcd, add_a, add_b, add_cin}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 0);
    chk("lit_6912", {cout, error, sum_bcd}, {2'b00, 16'h6912});
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    chk("lit_9999", {cout, sum_bcd}, {1'b1, 16'h0000});
    run_op(16'h4999, 16'h5000, 1'b1, 0);
    chk("lit_4999", {cout, sum_bcd}, {1'b1, 16'h0000});
    run_op(16'h0000, 16'h0000, 1'b1, 0);
    chk("lit_cin", {cout, sum_bcd}, {1'b0, 16'h0001});
    run_op(16'h12A4, 16'h0001, 1'b0, 0);
    chk("lit_err", error, 1);
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    chk("lit_err_clr", {error, sum_bcd}, {1'b0, 16'h0002});
    run_op(16'h2468, 16'h1357, 1'b0, 1);
    chk("lit_spam", {cout, sum_bcd}, {1'b0, 16'h3825});
    run_op(16'h0500, 16'h0500, 1'b0, 0);
    chk("lit_next", sum_bcd, 16'h1000);

    // Reset two cycles into ADD aborts with no done pulse
    @(negedge clk);
    a_bcd = 16'h5555; b_bcd = 16'h5555; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_abort", {busy, done, cout, error, sum_bcd}, '0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    run_op(16'h0999, 16'h0001, 1'b0, 0);
    chk("lit_after_rst", {cout, sum_bcd}, {1'b0, 16'h1000});

    for (int i = 0; i < 40; i++)
      run_op(rand_bcd(i % 4 == 3), rand_bcd(0), 1'($urandom), (i % 5 == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller that time-shares a single one-digit BCD_adder slice to add two multi-digit packed-BCD operands. It latches the operands on start and feeds one digit pair per cycle to the external slice, least-significant digit first. It chains the slice carry between digits and assembles the packed-BCD sum. The block sits between the operand/display logic and the BCD_adder instance; the slice stays purely combinational.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_bcd  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b_bcd  input  4*DIGITS  operand B, packed BCD
cin  input  1  initial carry-in; latched with operands
add_a  output  4  digit to slice input a
add_b  output  4  digit to slice input b
add_cin  output  1  carry to slice input cin
add_s0  input  4  slice ones-digit result
add_cout  input  1  slice decimal carry-out
add_error  input  1  slice invalid-digit flag
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse when the result is valid
sum_bcd  output  4*DIGITS  packed-BCD sum; holds until next start
cout  output  1  final decimal carry; holds until next start
error  output  1  sticky invalid-digit flag for the last operation

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, cout, error=0; sum_bcd=0; add_a, add_b, add_cin=0; operand shift registers and digit counter=0. Reset mid-operation aborts immediately, and no done is issued.
- FSM states: IDLE, ADD, DONE.
- IDLE, start=1 at edge T:
  - Latch a_bcd, b_bcd, cin into shift registers.
  - Clear sum_bcd, cout, error, digit counter.
  - Go to ADD; busy=1 from T.
- ADD, one digit per cycle:
  - add_a/add_b are the low nibbles of the A/B shift registers; add_cin is the carry register. All are registered, so nothing combinational runs from inputs to outputs.
  - At each edge: shift add_s0 into sum_bcd from the top, so after DIGITS shifts digit 0 lands in [3:0].
  - Same edge: carry register <= add_cout; error <= error | add_error; shift operands right by 4; increment counter.
  - After the edge capturing digit DIGITS-1: go to DONE, cout <= add_cout, busy=0.
- DONE: done=1 for exactly one cycle, then IDLE. sum_bcd, cout, error stay valid and stable until the next accepted start.
- Latency: start accepted at edge T, so done is high in cycle T+DIGITS+1 (DIGITS=4: 5 cycles).
- start while busy or in DONE: ignored, with no queueing.
- Error handling: processing continues to completion. sum_bcd digits are exactly the add_s0 values returned, and error=1 at done if any digit flagged. A digit >9 in either operand must raise add_error in the slice.
- Arithmetic: each digit result is 0–9 with carry 0/1. Overflow beyond DIGITS digits is reported only via cout; sum_bcd wraps.
- add_* outputs in IDLE/DONE hold their last values; the slice result is ignored outside ADD.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse → busy 4 cycles; done at T+5; sum_bcd=0x6912, cout=0, error=0.
- a=0x9999, b=0x0001, cin=0 → sum_bcd=0x0000, cout=1; add_cin observed 1 on digits 1–3.
- a=0x4999, b=0x5000, cin=1 → sum_bcd=0x0000, cout=1; a second case with a=0x0000, b=0x0000, cin=1 → sum_bcd=0x0001, cout=0.
- a=0x12A4, b=0x0001 → error=1 at done; a following valid operation (0x0001+0x0001) → error=0, sum_bcd=0x0002.
- start re-asserted every cycle during ADD with different operands → ignored; result matches the first operands. A start in the DONE cycle is also ignored; start in the next IDLE cycle is accepted.
- rst_n low two cycles into ADD → busy, done, sum_bcd, cout, error immediately 0, no done pulse; a fresh start then completes normally.
